// File: rtl/stereo_rd_arbiter_if.sv
// stereo_rd_arbiter_if: requester, return-beat and AXI read-channel signals of the stereo read arbiter
interface stereo_rd_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTSTANDING = 4
);
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [ADDR_WIDTH-1:0] req0_addr, req1_addr;
  logic [7:0] req0_len, req1_len;
  logic rd0_valid, rd1_valid, rd0_ready, rd1_ready, rd0_last, rd1_last;
  logic [DATA_WIDTH-1:0] rd0_data, rd1_data;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [7:0] m_arlen;
  logic m_arvalid, m_arready;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic m_rlast, m_rvalid, m_rready;
  logic [$clog2(MAX_OUTSTANDING):0] outstanding;
  logic busy;
  modport slave (
    input  req0_valid, req1_valid, req0_addr, req1_addr, req0_len, req1_len,
    input  rd0_ready, rd1_ready, m_arready, m_rdata, m_rlast, m_rvalid,
    output req0_ready, req1_ready, rd0_valid, rd1_valid, rd0_data, rd1_data, rd0_last, rd1_last,
    output m_araddr, m_arlen, m_arvalid, m_rready, outstanding, busy
  );
  modport master (
    output req0_valid, req1_valid, req0_addr, req1_addr, req0_len, req1_len,
    output rd0_ready, rd1_ready, m_arready, m_rdata, m_rlast, m_rvalid,
    input  req0_ready, req1_ready, rd0_valid, rd1_valid, rd0_data, rd1_data, rd0_last, rd1_last,
    input  m_araddr, m_arlen, m_arvalid, m_rready, outstanding, busy
  );
endinterface

// File: rtl/stereo_rd_arbiter.sv
// stereo_rd_arbiter: round-robin sharing of one AXI read port between two line fetchers with in-order R routing
module stereo_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic aclk,
  input logic aresetn,
  stereo_rd_arbiter_if.slave bus
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  typedef enum logic {IDLE, ISSUE} state_e;
  state_e state_q, state_d;
  logic last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0] len_q, len_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic grant, full, empty, head, push, pop, idle;
  always_comb begin
    idle = state_q == IDLE;
    full = cnt_q == (PW+1)'(MAX_OUTSTANDING);
    empty = cnt_q == '0;
    head = fifo_q[rd_q];
    grant = (bus.req0_valid && bus.req1_valid) ? !last_grant_q : bus.req1_valid;
    // aresetn gate keeps the combinational readies low while reset is held
    bus.req0_ready = aresetn && idle && !full && !grant;
    bus.req1_ready = aresetn && idle && !full && grant;
    push = grant ? bus.req1_valid && bus.req1_ready : bus.req0_valid && bus.req0_ready;
    bus.m_rready = !empty && (head ? bus.rd1_ready : bus.rd0_ready);
    pop = bus.m_rvalid && bus.m_rready && bus.m_rlast;
    bus.rd0_valid = bus.m_rvalid && !empty && !head;
    bus.rd1_valid = bus.m_rvalid && !empty && head;
    bus.rd0_data = bus.m_rdata;
    bus.rd1_data = bus.m_rdata;
    bus.rd0_last = bus.m_rlast;
    bus.rd1_last = bus.m_rlast;
    bus.m_arvalid = state_q == ISSUE;
    bus.m_araddr = addr_q;
    bus.m_arlen = len_q;
    bus.outstanding = cnt_q;
    bus.busy = !idle || !empty;
    state_d = push ? ISSUE : (!idle && bus.m_arready) ? IDLE : state_q;
    addr_d = push ? (grant ? bus.req1_addr : bus.req0_addr) : addr_q;
    len_d = push ? (grant ? bus.req1_len : bus.req0_len) : len_q;
    last_grant_d = push ? grant : last_grant_q;
    fifo_d = fifo_q;
    if (push) fifo_d[wr_q] = grant;
    wr_d = push ? wr_q + PW'(1) : wr_q;
    rd_d = pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      last_grant_q <= 1'b1;
      addr_q <= '0;
      len_q <= '0;
      fifo_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      addr_q <= addr_d;
      len_q <= len_d;
      fifo_q <= fifo_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_stereo_rd_arbiter.sv
// tb_stereo_rd_arbiter: scoreboard bench with requester queues, an AXI read slave model and per-scenario tasks
module tb_stereo_rd_arbiter;
  typedef struct {logic [31:0] addr; logic [7:0] len; logic dest;} burst_t;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;
  stereo_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) bus ();
  stereo_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
    .aclk(aclk), .aresetn(aresetn), .bus(bus)
  );
  int vectors = 0;
  int miscompares = 0;
  burst_t rq0[$], rq1[$], ar_exp[$], r_pend[$];
  logic grants[$];
  int traj[$];
  bit req_en, r_en, r_err, arready, rdy0, rdy1;
  int beat, cnt0, cnt1, acc0, acc1, peak, last_out;

  function automatic burst_t mk(logic [31:0] a, logic [7:0] l, logic d);
    burst_t b;
    b.addr = a;
    b.len = l;
    b.dest = d;
    return b;
  endfunction

  function automatic void clear_tb();
    rq0.delete(); rq1.delete(); ar_exp.delete(); r_pend.delete(); grants.delete(); traj.delete();
    beat = 0; cnt0 = 0; cnt1 = 0; acc0 = 0; acc1 = 0; peak = 0; last_out = int'(bus.outstanding);
  endfunction

  // Bench drives all DUT inputs 2 time units after each rising edge
  initial forever begin
    @(posedge aclk); #2;
    bus.req0_valid = req_en && rq0.size() > 0;
    bus.req0_addr = rq0.size() > 0 ? rq0[0].addr : 32'h0;
    bus.req0_len = rq0.size() > 0 ? rq0[0].len : 8'h0;
    bus.req1_valid = req_en && rq1.size() > 0;
    bus.req1_addr = rq1.size() > 0 ? rq1[0].addr : 32'h0;
    bus.req1_len = rq1.size() > 0 ? rq1[0].len : 8'h0;
    bus.m_arready = arready;
    bus.rd0_ready = rdy0;
    bus.rd1_ready = rdy1;
    bus.m_rvalid = r_err || (r_en && r_pend.size() > 0);
    bus.m_rdata = r_pend.size() > 0 ? r_pend[0].addr + 32'(beat) : 32'hdead_beef;
    bus.m_rlast = r_pend.size() > 0 ? beat == int'(r_pend[0].len) : 1'b1;
  end

  always @(negedge aclk) begin : mon
    burst_t e;
    logic [31:0] d;
    logic l;
    if (aresetn) begin
      if (bus.req0_valid && bus.req0_ready) begin void'(rq0.pop_front()); acc0++; grants.push_back(1'b0); end
      if (bus.req1_valid && bus.req1_ready) begin void'(rq1.pop_front()); acc1++; grants.push_back(1'b1); end
      if (bus.m_arvalid && bus.m_arready) begin
        vectors++;
        if (ar_exp.size() == 0) begin
          miscompares++;
          $display("FAIL ar_unexpected: got addr %h len %0d, none expected", bus.m_araddr, bus.m_arlen);
        end else begin
          e = ar_exp.pop_front();
          if (bus.m_araddr !== e.addr || bus.m_arlen !== e.len) begin
            miscompares++;
            $display("FAIL ar_order: got addr %h len %0d, want addr %h len %0d", bus.m_araddr, bus.m_arlen, e.addr, e.len);
          end
          r_pend.push_back(e);
        end
      end
      if (bus.m_rvalid && bus.m_rready && !r_err) begin
        vectors++;
        if (r_pend.size() == 0) begin
          miscompares++;
          $display("FAIL r_unexpected: beat acknowledged with no burst outstanding");
        end else begin
          e = r_pend[0];
          d = e.dest ? bus.rd1_data : bus.rd0_data;
          l = e.dest ? bus.rd1_last : bus.rd0_last;
          if ((e.dest ? {bus.rd1_valid, bus.rd0_valid} : {bus.rd0_valid, bus.rd1_valid}) !== 2'b10) begin
            miscompares++;
            $display("FAIL r_route: rd0_valid=%b rd1_valid=%b, want only rd%0d", bus.rd0_valid, bus.rd1_valid, e.dest);
          end else if (d !== e.addr + 32'(beat) || l !== (beat == int'(e.len))) begin
            miscompares++;
            $display("FAIL r_beat: got data %h last %b, want data %h last %b", d, l, e.addr + 32'(beat), beat == int'(e.len));
          end
          if (e.dest) cnt1++; else cnt0++;
          if (beat == int'(e.len)) begin void'(r_pend.pop_front()); beat = 0; end else beat++;
        end
      end
      if (int'(bus.outstanding) != last_out) begin last_out = int'(bus.outstanding); traj.push_back(last_out); end
      if (int'(bus.outstanding) > peak) peak = int'(bus.outstanding);
    end
  end

  task automatic do_reset();
    @(posedge aclk); #1;
    aresetn = 1'b0; req_en = 0; r_en = 0; r_err = 0; arready = 1; rdy0 = 1; rdy1 = 1;
    clear_tb();
    last_out = 0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge aclk); #1;
    aresetn = 1'b0; r_err = 0; arready = 1; rdy0 = 1; rdy1 = 1;
    clear_tb();
    last_out = 0;
    rq0.push_back(mk(32'h1000, 8'd7, 1'b0));
    rq1.push_back(mk(32'h2000, 8'd7, 1'b1));
    ar_exp.push_back(mk(32'h1000, 8'd7, 1'b0));
    ar_exp.push_back(mk(32'h2000, 8'd7, 1'b1));
    req_en = 1; r_en = 1;
    repeat (2) @(negedge aclk);
    vectors++; if (bus.m_arvalid !== 1'b0) begin miscompares++; $display("FAIL rst_arvalid: got %b want 0", bus.m_arvalid); end
    vectors++; if (bus.m_araddr !== 32'h0) begin miscompares++; $display("FAIL rst_araddr: got %h want 0", bus.m_araddr); end
    vectors++; if (bus.m_arlen !== 8'h0) begin miscompares++; $display("FAIL rst_arlen: got %h want 0", bus.m_arlen); end
    vectors++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin miscompares++; $display("FAIL rst_req_ready: got %b%b want 00", bus.req0_ready, bus.req1_ready); end
    vectors++; if (bus.m_rready !== 1'b0) begin miscompares++; $display("FAIL rst_rready: got %b want 0", bus.m_rready); end
    vectors++; if ({bus.rd0_valid, bus.rd1_valid} !== 2'b00) begin miscompares++; $display("FAIL rst_rd_valid: got %b%b want 00", bus.rd0_valid, bus.rd1_valid); end
    vectors++; if (bus.outstanding !== 3'd0) begin miscompares++; $display("FAIL rst_outstanding: got %0d want 0", bus.outstanding); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_basic();
    @(posedge aclk); #1 aresetn = 1'b1;
    for (int i = 0; i < 100 && !(cnt0 == 8 && cnt1 == 8 && bus.outstanding == 0); i++) begin @(negedge aclk); #1; end
    vectors++; if (cnt0 != 8 || cnt1 != 8) begin miscompares++; $display("FAIL basic_beats: got rd0 %0d rd1 %0d want 8 8", cnt0, cnt1); end
    vectors++; if (grants.size() != 2 || grants[0] !== 1'b0 || grants[1] !== 1'b1) begin miscompares++; $display("FAIL basic_grants: got %0d grants want 0,1", grants.size()); end
    vectors++;
    if (traj.size() != 4 || traj[0] != 1 || traj[1] != 2 || traj[2] != 1 || traj[3] != 0) begin
      miscompares++;
      $display("FAIL basic_outstanding: got %0d transitions (first %0d) want 1,2,1,0", traj.size(), traj.size() > 0 ? traj[0] : -1);
    end
  endtask

  task automatic test_alternation();
    logic exp_g;
    do_reset();
    @(posedge aclk); #1;
    for (int i = 0; i < 3; i++) begin
      rq0.push_back(mk(32'h100 + 32'(16 * i), 8'd0, 1'b0));
      rq1.push_back(mk(32'h200 + 32'(16 * i), 8'd0, 1'b1));
      ar_exp.push_back(mk(32'h100 + 32'(16 * i), 8'd0, 1'b0));
      ar_exp.push_back(mk(32'h200 + 32'(16 * i), 8'd0, 1'b1));
    end
    req_en = 1; r_en = 1;
    for (int i = 0; i < 200 && !(acc0 + acc1 == 6 && ar_exp.size() == 0 && r_pend.size() == 0 && !bus.busy); i++) begin @(negedge aclk); #1; end
    for (int i = 0; i < 6; i++) begin
      exp_g = i[0];
      vectors++;
      if (i >= grants.size() || grants[i] !== exp_g) begin
        miscompares++;
        $display("FAIL alt_grant[%0d]: got %0d want %0d", i, i < grants.size() ? int'(grants[i]) : -1, exp_g);
      end
    end
    vectors++; if (cnt0 != 3 || cnt1 != 3) begin miscompares++; $display("FAIL alt_beats: got rd0 %0d rd1 %0d want 3 3", cnt0, cnt1); end
  endtask

  task automatic test_fifo_full();
    @(posedge aclk); #1;
    clear_tb();
    r_en = 0;
    for (int i = 0; i < 5; i++) begin
      rq0.push_back(mk(32'h3000 + 32'(16 * i), 8'd0, 1'b0));
      ar_exp.push_back(mk(32'h3000 + 32'(16 * i), 8'd0, 1'b0));
    end
    req_en = 1;
    repeat (20) begin @(negedge aclk); #1; end
    vectors++; if (acc0 != 4) begin miscompares++; $display("FAIL full_accepts: got %0d want 4", acc0); end
    vectors++; if (bus.outstanding !== 3'd4) begin miscompares++; $display("FAIL full_outstanding: got %0d want 4", bus.outstanding); end
    vectors++; if (bus.req0_valid !== 1'b1 || bus.req0_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got valid %b ready %b want 1 0", bus.req0_valid, bus.req0_ready); end
    @(posedge aclk); #1 r_en = 1;
    for (int i = 0; i < 200 && !(acc0 == 5 && ar_exp.size() == 0 && r_pend.size() == 0 && !bus.busy); i++) begin @(negedge aclk); #1; end
    vectors++; if (acc0 != 5 || cnt0 != 5) begin miscompares++; $display("FAIL full_drain: got accepts %0d beats %0d want 5 5", acc0, cnt0); end
    vectors++; if (peak != 4) begin miscompares++; $display("FAIL full_peak: got %0d want 4", peak); end
  endtask

  task automatic test_ar_stall();
    @(posedge aclk); #1;
    clear_tb();
    arready = 0; r_en = 1;
    rq1.push_back(mk(32'h4444, 8'd3, 1'b1));
    rq0.push_back(mk(32'h5550, 8'd1, 1'b0));
    ar_exp.push_back(mk(32'h4444, 8'd3, 1'b1));
    ar_exp.push_back(mk(32'h5550, 8'd1, 1'b0));
    req_en = 1;
    for (int i = 0; i < 20 && !bus.m_arvalid; i++) begin @(negedge aclk); #1; end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (bus.m_arvalid !== 1'b1) begin miscompares++; $display("FAIL stall_arvalid[%0d]: got %b want 1", i, bus.m_arvalid); end
      vectors++; if (bus.m_araddr !== 32'h4444) begin miscompares++; $display("FAIL stall_araddr[%0d]: got %h want 4444", i, bus.m_araddr); end
      vectors++; if (bus.m_arlen !== 8'd3) begin miscompares++; $display("FAIL stall_arlen[%0d]: got %0d want 3", i, bus.m_arlen); end
      vectors++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin miscompares++; $display("FAIL stall_req_ready[%0d]: got %b%b want 00", i, bus.req0_ready, bus.req1_ready); end
      @(negedge aclk); #1;
    end
    @(posedge aclk); #1 arready = 1;
    for (int i = 0; i < 100 && !(ar_exp.size() == 0 && r_pend.size() == 0 && !bus.busy); i++) begin @(negedge aclk); #1; end
    vectors++; if (cnt1 != 4 || cnt0 != 2) begin miscompares++; $display("FAIL stall_beats: got rd0 %0d rd1 %0d want 2 4", cnt0, cnt1); end
  endtask

  task automatic test_rd_stall();
    @(posedge aclk); #1;
    clear_tb();
    rq1.push_back(mk(32'h6000, 8'd7, 1'b1));
    ar_exp.push_back(mk(32'h6000, 8'd7, 1'b1));
    req_en = 1; r_en = 1;
    for (int i = 0; i < 50 && cnt1 != 3; i++) begin @(negedge aclk); #1; end
    @(posedge aclk); #1 rdy1 = 0;
    repeat (4) begin
      @(negedge aclk);
      vectors++; if (bus.m_rready !== 1'b0) begin miscompares++; $display("FAIL rstall_rready: got %b want 0", bus.m_rready); end
      vectors++; if ({bus.rd0_valid, bus.rd1_valid} !== 2'b01) begin miscompares++; $display("FAIL rstall_route: got rd0 %b rd1 %b want 0 1", bus.rd0_valid, bus.rd1_valid); end
      #1;
    end
    vectors++; if (cnt1 != 3 || cnt0 != 0) begin miscompares++; $display("FAIL rstall_hold: got rd0 %0d rd1 %0d want 0 3", cnt0, cnt1); end
    @(posedge aclk); #1 rdy1 = 1;
    for (int i = 0; i < 50 && !(r_pend.size() == 0 && !bus.busy); i++) begin @(negedge aclk); #1; end
    vectors++; if (cnt1 != 8 || cnt0 != 0) begin miscompares++; $display("FAIL rstall_resume: got rd0 %0d rd1 %0d want 0 8", cnt0, cnt1); end
  endtask

  task automatic test_reset_mid();
    @(posedge aclk); #1;
    clear_tb();
    r_en = 0;
    rq0.push_back(mk(32'h7000, 8'd3, 1'b0));
    rq0.push_back(mk(32'h7100, 8'd3, 1'b0));
    ar_exp.push_back(mk(32'h7000, 8'd3, 1'b0));
    ar_exp.push_back(mk(32'h7100, 8'd3, 1'b0));
    req_en = 1;
    for (int i = 0; i < 20 && bus.outstanding != 3'd2; i++) begin @(negedge aclk); #1; end
    vectors++; if (bus.outstanding !== 3'd2) begin miscompares++; $display("FAIL mid_setup: got outstanding %0d want 2", bus.outstanding); end
    @(posedge aclk); #1;
    aresetn = 1'b0; req_en = 0;
    clear_tb();
    @(posedge aclk);
    @(negedge aclk);
    vectors++; if (bus.outstanding !== 3'd0) begin miscompares++; $display("FAIL mid_outstanding: got %0d want 0", bus.outstanding); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.m_arvalid !== 1'b0) begin miscompares++; $display("FAIL mid_arvalid: got %b want 0", bus.m_arvalid); end
    vectors++; if (bus.m_rready !== 1'b0) begin miscompares++; $display("FAIL mid_rready: got %b want 0", bus.m_rready); end
    @(posedge aclk); #1;
    aresetn = 1'b1; r_err = 1;
    @(posedge aclk);
    repeat (3) begin
      @(negedge aclk);
      vectors++; if (bus.m_rvalid !== 1'b1 || bus.m_rready !== 1'b0) begin miscompares++; $display("FAIL orphan_rready: got rvalid %b rready %b want 1 0", bus.m_rvalid, bus.m_rready); end
      vectors++; if ({bus.rd0_valid, bus.rd1_valid} !== 2'b00) begin miscompares++; $display("FAIL orphan_rd_valid: got %b%b want 00", bus.rd0_valid, bus.rd1_valid); end
    end
    @(posedge aclk); #1 r_err = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_alternation();
    test_fifo_full();
    test_ar_stall();
    test_rd_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stereo_rd_arbiter.md
# stereo_rd_arbiter

Shares the single AXI4 read-address/read-data master port to frame memory between the two line fetchers (left camera = requester 0, right camera = requester 1) of the stereoscopic comparator. It accepts burst requests from both fetchers, issues them one at a time on the AR channel in round-robin order, and routes returned R beats back to the requester that issued each burst. It sits between the line fetchers and the AXI interconnect, under the frame controller that starts line and block fetches.

## Interface

- ADDR_WIDTH, 32, byte address width of requests and m_araddr
- DATA_WIDTH, 32, R beat width
- MAX_OUTSTANDING, 4, bursts in flight; power of two, 2..16

- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low; clock aclk
- req0_valid / req1_valid  in  1  burst request pending
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_addr / req1_addr  in  ADDR_WIDTH  burst start address
- req0_len / req1_len  in  8  AXI arlen (beats-1)
- rd0_valid / rd1_valid  out  1  return beat valid
- rd0_ready / rd1_ready  in  1  requester accepts beat
- rd0_data / rd1_data  out  DATA_WIDTH  return beat data
- rd0_last / rd1_last  out  1  last beat of burst
- m_araddr  out  ADDR_WIDTH  AXI AR address
- m_arlen  out  8  AXI AR length
- m_arvalid  out  1  AXI AR valid
- m_arready  in  1  AXI AR ready
- m_rdata  in  DATA_WIDTH  AXI R data
- m_rlast  in  1  AXI R last
- m_rvalid  in  1  AXI R valid
- m_rready  out  1  AXI R ready
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  bursts issued, last beat not yet returned
- busy  out  1  AR FSM not IDLE or outstanding != 0

## Operation

- AR FSM states: IDLE, ISSUE.
- IDLE: grant = requester with valid; if both valid, the one not granted last (last_grant). reqN_ready = (state==IDLE) && !fifo_full && grant==N, combinational. On reqN_valid && reqN_ready: register addr/len into m_araddr/m_arlen, push N into order FIFO, update last_grant = N, go ISSUE.
- ISSUE: m_arvalid=1, m_araddr/m_arlen stable; on m_arready go IDLE.
- Order FIFO: depth MAX_OUTSTANDING, 1-bit entries, head = destination of current R burst. fifo_full blocks all reqN_ready.
- R routing (combinational, no buffering): rdN_valid = m_rvalid && !fifo_empty && head==N; rdN_data/rdN_last = m_rdata/m_rlast on both outputs; m_rready = !fifo_empty && rd[head]_ready.
- Pop on m_rvalid && m_rready && m_rlast. Push and pop in same cycle: outstanding unchanged.
- outstanding increments on push, decrements on pop; equals FIFO occupancy.
- R beat arriving with FIFO empty: m_rready held 0, rdN_valid 0 (protocol error, never acknowledged).
- Requester must hold valid/addr/len stable until ready; dropping valid before ready withdraws the request with no side effect.

## Timing

- Reset values: m_arvalid 0, m_araddr 0, m_arlen 0, req0_ready/req1_ready 0, m_rready 0, rd0_valid/rd1_valid 0, outstanding 0, busy 0, FIFO empty, state IDLE, last_grant = 1 (requester 0 wins first tie).
- Request accepted cycle T -> m_arvalid high from T+1; m_arready at T+1 -> IDLE at T+2, next accept possible at T+2 (max one AR per 2 cycles).
- R path zero latency: rdN_valid same cycle as m_rvalid.
- Outstanding visible cycle after push/pop.
- Reset mid-operation: all in-flight bursts and FIFO contents discarded; interconnect is reset together with this block.

## Test plan

- Both req valid from reset, addr 0x1000/0x2000, len 7, m_arready always 1 -> AR order 0x1000 then 0x2000; 8 R beats each routed to rd0 then rd1; outstanding 0->1->2->1->0.
- Requester 0 only, 4 back-to-back len 0 requests, R held off -> 4 accepts, 5th request sees req0_ready 0 until first R beat with m_rlast pops; outstanding peaks at 4.
- Both valid continuously, 6 grants -> strict alternation 0,1,0,1,0,1.
- m_arready held low 5 cycles during ISSUE -> m_araddr/m_arlen stable, m_arvalid high, req0_ready/req1_ready 0 throughout.
- rd1_ready low mid-burst with head==1 -> m_rready 0, beats stall, no beat delivered to rd0; resumes when rd1_ready rises.
- aresetn low with 2 bursts outstanding -> next cycle outstanding 0, busy 0, m_arvalid 0, m_rready 0.
